mmu_xlate: RTL and testbench

Address-translation front end between the CPU data port and the memory bus. It holds a small fully-associative micro-TLB, which avoids a full TLB walk for recently used pages. On a miss it issues a lookup to the page-walking `tlb` block and consumes the returned page entry (`v_ent_o`, `v_page_o`, `v_ack_o`). It then forms the physical address and performs the CPU's read or write on the memory bus, or reports a page fault.

---
 rtl/mmu_xlate_if.sv | 41 ++++
 rtl/mmu_xlate.sv | 237 +++++++++++++++++++++++
 tb/tb_mmu_xlate.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_xlate_if.sv
// Bus bundle for mmu_xlate: CPU data port, page-walker lookup channel and memory bus.
// The slave modport is the translator's view; master is the surrounding system.
`timescale 1ns/1ps

interface mmu_xlate_if;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_rd_i;
  logic        cpu_we_i;
  logic [31:0] cpu_data_o;
  logic        cpu_ack_o;
  logic        cpu_fault_o;
  logic [31:0] fault_addr_o;
  logic        flush_i;
  logic [31:0] tlb_addr_o;
  logic        tlb_lookup_o;
  logic [31:0] tlb_ent_i;
  logic [19:0] tlb_page_i;
  logic        tlb_ack_i;
  logic        tlb_fault_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_rd_o;
  logic        mem_we_o;
  logic        mem_ack_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_rd_i, cpu_we_i, flush_i,
           tlb_ent_i, tlb_page_i, tlb_ack_i, tlb_fault_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_ack_o, cpu_fault_o, fault_addr_o, tlb_addr_o, tlb_lookup_o,
           mem_addr_o, mem_data_o, mem_rd_o, mem_we_o
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_rd_i, cpu_we_i, flush_i,
           tlb_ent_i, tlb_page_i, tlb_ack_i, tlb_fault_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_ack_o, cpu_fault_o, fault_addr_o, tlb_addr_o, tlb_lookup_o,
           mem_addr_o, mem_data_o, mem_rd_o, mem_we_o
  );
endinterface

// File: rtl/mmu_xlate.sv
// Address translation front end with a round-robin micro-TLB in front of the page walker.
// Define MMU_XLATE_WP_EN to store the writable bit and fault writes to read-only pages.
`timescale 1ns/1ps

module mmu_xlate #(
  parameter int UTLB_ENTRIES = 2
) (
  input  logic        clk,
  input  logic        rst,
  mmu_xlate_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, ACCESS, DONE, FAULT} state_e;

  state_e state_q, state_d;

  logic [31:0] vaddr_q, vaddr_d;
  logic        we_q, we_d;
  logic [1:0]  rr_q, rr_d;

  logic [UTLB_ENTRIES-1:0]       valid_q, valid_d;
  logic [UTLB_ENTRIES-1:0][19:0] tag_q, tag_d;
  logic [UTLB_ENTRIES-1:0][19:0] pfn_q, pfn_d;
`ifdef MMU_XLATE_WP_EN
  logic [UTLB_ENTRIES-1:0]       wr_q, wr_d;
`endif

  logic [31:0] cpu_data_q, cpu_data_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        cpu_fault_q, cpu_fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] tlb_addr_q, tlb_addr_d;
  logic        tlb_lookup_q, tlb_lookup_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_we_q, mem_we_d;

  logic        req;
  logic        hit;
  logic        hit_deny;
  logic [19:0] hit_pfn;
  logic        fill_ok;
  logic        fill_deny;
  logic        unused_ent;

  assign req        = bus.cpu_rd_i | bus.cpu_we_i;
  assign unused_ent = ^bus.tlb_ent_i[11:1];

  // Associative match against the live CPU address so a hit can start the bus access immediately.
  always_comb begin
    hit      = 1'b0;
    hit_pfn  = '0;
    hit_deny = 1'b0;
    for (int i = 0; i < UTLB_ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == bus.cpu_addr_i[31:12])) begin
        hit     = 1'b1;
        hit_pfn = pfn_q[i];
`ifdef MMU_XLATE_WP_EN
        hit_deny = bus.cpu_we_i && !wr_q[i];
`endif
      end
    end
    fill_ok = !bus.tlb_fault_i && bus.tlb_ent_i[0];
`ifdef MMU_XLATE_WP_EN
    fill_deny = we_q && !bus.tlb_ent_i[1];
`else
    fill_deny = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    we_d         = we_q;
    rr_d         = rr_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    pfn_d        = pfn_q;
`ifdef MMU_XLATE_WP_EN
    wr_d         = wr_q;
`endif
    cpu_data_d   = cpu_data_q;
    cpu_ack_d    = cpu_ack_q;
    cpu_fault_d  = cpu_fault_q;
    fault_addr_d = fault_addr_q;
    tlb_addr_d   = tlb_addr_q;
    tlb_lookup_d = tlb_lookup_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_rd_d     = mem_rd_q;
    mem_we_d     = mem_we_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          vaddr_d    = bus.cpu_addr_i;
          we_d       = bus.cpu_we_i;
          mem_data_d = bus.cpu_data_i;
          if (hit && hit_deny) begin
            state_d      = FAULT;
            cpu_ack_d    = 1'b1;
            cpu_fault_d  = 1'b1;
            fault_addr_d = bus.cpu_addr_i;
          end else if (hit) begin
            state_d    = ACCESS;
            mem_addr_d = {hit_pfn, bus.cpu_addr_i[11:0]};
            mem_rd_d   = !bus.cpu_we_i;
            mem_we_d   = bus.cpu_we_i;
          end else begin
            state_d      = LOOKUP;
            tlb_lookup_d = 1'b1;
            tlb_addr_d   = bus.cpu_addr_i;
          end
        end
      end

      // A write-protect denial still fills the entry so later hits see the same permission.
      LOOKUP: begin
        if (bus.tlb_ack_i) begin
          tlb_lookup_d = 1'b0;
          if (!fill_ok || fill_deny) begin
            state_d      = FAULT;
            cpu_ack_d    = 1'b1;
            cpu_fault_d  = 1'b1;
            fault_addr_d = vaddr_q;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = {bus.tlb_ent_i[31:12], vaddr_q[11:0]};
            mem_rd_d   = !we_q;
            mem_we_d   = we_q;
          end
          if (fill_ok) begin
            for (int i = 0; i < UTLB_ENTRIES; i++) begin
              if (i == int'(rr_q)) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = bus.tlb_page_i;
                pfn_d[i]   = bus.tlb_ent_i[31:12];
`ifdef MMU_XLATE_WP_EN
                wr_d[i]    = bus.tlb_ent_i[1];
`endif
              end
            end
            rr_d = (rr_q == 2'(UTLB_ENTRIES - 1)) ? 2'd0 : rr_q + 2'd1;
          end
        end
      end

      ACCESS: begin
        if (bus.mem_ack_i) begin
          state_d   = DONE;
          mem_rd_d  = 1'b0;
          mem_we_d  = 1'b0;
          cpu_ack_d = 1'b1;
          if (!we_q) begin
            cpu_data_d = bus.mem_data_i;
          end
        end
      end

      DONE: begin
        state_d   = IDLE;
        cpu_ack_d = 1'b0;
      end

      FAULT: begin
        state_d     = IDLE;
        cpu_ack_d   = 1'b0;
        cpu_fault_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    if (bus.flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      vaddr_q      <= '0;
      we_q         <= 1'b0;
      rr_q         <= '0;
      valid_q      <= '0;
      tag_q        <= '0;
      pfn_q        <= '0;
`ifdef MMU_XLATE_WP_EN
      wr_q         <= '0;
`endif
      cpu_data_q   <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_fault_q  <= 1'b0;
      fault_addr_q <= '0;
      tlb_addr_q   <= '0;
      tlb_lookup_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      we_q         <= we_d;
      rr_q         <= rr_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      pfn_q        <= pfn_d;
`ifdef MMU_XLATE_WP_EN
      wr_q         <= wr_d;
`endif
      cpu_data_q   <= cpu_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_fault_q  <= cpu_fault_d;
      fault_addr_q <= fault_addr_d;
      tlb_addr_q   <= tlb_addr_d;
      tlb_lookup_q <= tlb_lookup_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_rd_q     <= mem_rd_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign bus.cpu_data_o   = cpu_data_q;
  assign bus.cpu_ack_o    = cpu_ack_q;
  assign bus.cpu_fault_o  = cpu_fault_q;
  assign bus.fault_addr_o = fault_addr_q;
  assign bus.tlb_addr_o   = tlb_addr_q;
  assign bus.tlb_lookup_o = tlb_lookup_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign bus.mem_rd_o     = mem_rd_q;
  assign bus.mem_we_o     = mem_we_q;

endmodule

// File: tb/tb_mmu_xlate.sv
// Testbench for mmu_xlate: acts as CPU, page walker and memory, with a scoreboard queue
// of expected completions pushed at stimulus time and popped when the CPU ack arrives.
`timescale 1ns/1ps

module tb_mmu_xlate;

  localparam logic [31:0] MEM_KEY  = 32'hC0DE_5A5A;
  localparam int          MEM_WAIT = 1;

  typedef struct {
    int          lookups;
    logic [31:0] maddr;
    logic [31:0] data;
    logic        fault;
    logic [31:0] faddr;
    int          cycles;
  } exp_t;

  typedef struct {
    int          lookups;
    logic [31:0] taddr;
    int          mem_seen;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        mrd;
    logic        mwe;
    logic [31:0] data;
    logic        fault;
    logic [31:0] faddr;
    int          cycles;
    logic        ack_one;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mmu_xlate_if bus();

  mmu_xlate #(.UTLB_ENTRIES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Plays the CPU, walker and memory for one request; a walker ack answers each lookup cycle.
  task automatic drive(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [31:0] ent, input logic tfault, input logic flush_fill,
                       output obs_t o);
    int   cnt;
    logic done;
    o = '{default: 0};
    cnt = 0;
    done = 1'b0;
    @(negedge clk);
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wdata;
    bus.cpu_rd_i   = !we;
    bus.cpu_we_i   = we;
    for (int n = 1; n <= 64 && !done; n++) begin
      @(negedge clk);
      if (bus.tlb_lookup_o) begin
        o.lookups++;
        o.taddr         = bus.tlb_addr_o;
        bus.tlb_ack_i   = 1'b1;
        bus.tlb_ent_i   = ent;
        bus.tlb_page_i  = addr[31:12];
        bus.tlb_fault_i = tfault;
        bus.flush_i     = flush_fill;
      end else begin
        bus.tlb_ack_i   = 1'b0;
        bus.tlb_fault_i = 1'b0;
        bus.flush_i     = 1'b0;
      end
      if (bus.mem_rd_o || bus.mem_we_o) begin
        o.mem_seen++;
        o.maddr = bus.mem_addr_o;
        o.mdata = bus.mem_data_o;
        o.mrd   = bus.mem_rd_o;
        o.mwe   = bus.mem_we_o;
        cnt++;
        bus.mem_data_i = bus.mem_addr_o ^ MEM_KEY;
        bus.mem_ack_i  = (cnt == MEM_WAIT + 1);
      end else begin
        bus.mem_ack_i = 1'b0;
        cnt = 0;
      end
      if (bus.cpu_ack_o) begin
        done    = 1'b1;
        o.cycles = n;
        o.data  = bus.cpu_data_o;
        o.fault = bus.cpu_fault_o;
        o.faddr = bus.fault_addr_o;
        bus.cpu_rd_i = 1'b0;
        bus.cpu_we_i = 1'b0;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL timeout addr=%h: cpu_ack_o never seen, required within 64 cycles", addr);
      bus.cpu_rd_i = 1'b0;
      bus.cpu_we_i = 1'b0;
    end
    @(negedge clk);
    o.ack_one = !bus.cpu_ack_o && !bus.cpu_fault_o;
    bus.tlb_ack_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.flush_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cpu_addr_i = '0; bus.cpu_data_i = '0; bus.cpu_rd_i = 1'b0; bus.cpu_we_i = 1'b0;
    bus.flush_i = 1'b0; bus.tlb_ent_i = '0; bus.tlb_page_i = '0; bus.tlb_ack_i = 1'b0;
    bus.tlb_fault_i = 1'b0; bus.mem_data_i = '0; bus.mem_ack_i = 1'b0;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.cpu_ack_o, bus.cpu_fault_o, bus.tlb_lookup_o, bus.mem_rd_o, bus.mem_we_o} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_strobes got %b required 00000",
               {bus.cpu_ack_o, bus.cpu_fault_o, bus.tlb_lookup_o, bus.mem_rd_o, bus.mem_we_o});
    end
    n_cmp++;
    if ({bus.cpu_data_o, bus.fault_addr_o, bus.tlb_addr_o, bus.mem_addr_o, bus.mem_data_o} !== 160'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_buses got %h %h %h %h %h required all zero", bus.cpu_data_o,
               bus.fault_addr_o, bus.tlb_addr_o, bus.mem_addr_o, bus.mem_data_o);
    end
    rst = 1'b1;
    @(negedge clk);
    bus.tlb_ack_i = 1'b1;
    bus.mem_ack_i = 1'b1;
    @(negedge clk);
    bus.tlb_ack_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    n_cmp++;
    if ({bus.cpu_ack_o, bus.tlb_lookup_o, bus.mem_rd_o, bus.mem_we_o} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL stray_ack got %b required 0000",
               {bus.cpu_ack_o, bus.tlb_lookup_o, bus.mem_rd_o, bus.mem_we_o});
    end
  endtask

  task automatic test_cold_read();
    obs_t o;
    exp_t e;
    sb_q.push_back('{lookups: 1, maddr: 32'h0001_0123, data: 32'h0001_0123 ^ MEM_KEY,
                     fault: 1'b0, faddr: 32'h0, cycles: 4});
    drive(32'h0000_0123, 1'b0, 32'h0, 32'h0001_0001, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.lookups !== e.lookups) begin n_fail++; $display("[TB] FAIL cold_lookups got %0d required %0d", o.lookups, e.lookups); end
    n_cmp++;
    if (o.taddr !== 32'h0000_0123) begin n_fail++; $display("[TB] FAIL cold_tlb_addr got %h required 00000123", o.taddr); end
    n_cmp++;
    if (o.maddr !== e.maddr || o.mrd !== 1'b1 || o.mwe !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cold_mem got %h rd=%b we=%b required %h rd=1 we=0", o.maddr, o.mrd, o.mwe, e.maddr);
    end
    n_cmp++;
    if (o.data !== e.data) begin n_fail++; $display("[TB] FAIL cold_data got %h required %h", o.data, e.data); end
    n_cmp++;
    if (o.cycles !== e.cycles || o.ack_one !== 1'b1) begin
      n_fail++; $display("[TB] FAIL cold_timing got %0d cycles single=%b required %0d single=1", o.cycles, o.ack_one, e.cycles);
    end
  endtask

  task automatic test_hit();
    obs_t o;
    exp_t e;
    sb_q.push_back('{lookups: 0, maddr: 32'h0001_0456, data: 32'h0001_0456 ^ MEM_KEY,
                     fault: 1'b0, faddr: 32'h0, cycles: 3});
    drive(32'h0000_0456, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.lookups !== e.lookups) begin n_fail++; $display("[TB] FAIL hit_lookups got %0d required %0d", o.lookups, e.lookups); end
    n_cmp++;
    if (o.maddr !== e.maddr || o.data !== e.data) begin
      n_fail++; $display("[TB] FAIL hit_access got %h/%h required %h/%h", o.maddr, o.data, e.maddr, e.data);
    end
    n_cmp++;
    if (o.cycles !== e.cycles) begin n_fail++; $display("[TB] FAIL hit_latency got %0d required %0d", o.cycles, e.cycles); end
  endtask

  task automatic test_replacement();
    logic [31:0] addr[4] = '{32'h0000_1010, 32'h0040_0010, 32'h0000_0200, 32'h0040_0ABC};
    logic [31:0] ent[4]  = '{32'h0003_0001, 32'h0005_0003, 32'h0001_0001, 32'hFFFF_FFFF};
    obs_t o;
    exp_t e;
    sb_q.push_back('{lookups: 1, maddr: 32'h0003_0010, data: 32'h0003_0010 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    sb_q.push_back('{lookups: 1, maddr: 32'h0005_0010, data: 32'h0005_0010 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    sb_q.push_back('{lookups: 1, maddr: 32'h0001_0200, data: 32'h0001_0200 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    sb_q.push_back('{lookups: 0, maddr: 32'h0005_0ABC, data: 32'h0005_0ABC ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 3});
    for (int k = 0; k < 4; k++) begin
      drive(addr[k], 1'b0, 32'h0, ent[k], 1'b0, 1'b0, o);
      e = sb_q.pop_front();
      n_cmp++;
      if (o.lookups !== e.lookups || o.maddr !== e.maddr || o.data !== e.data) begin
        n_fail++;
        $display("[TB] FAIL repl_%0d got lookups=%0d addr=%h data=%h required lookups=%0d addr=%h data=%h",
                 k, o.lookups, o.maddr, o.data, e.lookups, e.maddr, e.data);
      end
    end
  endtask

  task automatic test_fault();
    obs_t o;
    exp_t e;
    sb_q.push_back('{lookups: 1, maddr: 32'h0, data: 32'h0, fault: 1'b1, faddr: 32'h0000_2000, cycles: 2});
    drive(32'h0000_2000, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.fault !== e.fault || o.faddr !== e.faddr || o.cycles !== e.cycles) begin
      n_fail++; $display("[TB] FAIL fault_np got fault=%b addr=%h cyc=%0d required fault=1 addr=%h cyc=%0d",
                         o.fault, o.faddr, o.cycles, e.faddr, e.cycles);
    end
    n_cmp++;
    if (o.mem_seen !== 0 || o.ack_one !== 1'b1) begin
      n_fail++; $display("[TB] FAIL fault_np_side got mem_cycles=%0d single=%b required 0 and 1", o.mem_seen, o.ack_one);
    end
    sb_q.push_back('{lookups: 1, maddr: 32'h0, data: 32'h0, fault: 1'b1, faddr: 32'h0000_3000, cycles: 2});
    drive(32'h0000_3000, 1'b1, 32'h5555_AAAA, 32'h0007_0003, 1'b1, 1'b0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.fault !== e.fault || o.faddr !== e.faddr || o.mem_seen !== 0) begin
      n_fail++; $display("[TB] FAIL fault_walk got fault=%b addr=%h mem_cycles=%0d required fault=1 addr=%h mem_cycles=0",
                         o.fault, o.faddr, o.mem_seen, e.faddr);
    end
  endtask

  task automatic test_flush();
    logic [31:0] addr[5] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_5008, 32'h0000_5008, 32'h0000_0044};
    logic [31:0] ent[5]  = '{32'h0001_0001, 32'h0001_0001, 32'h0009_0003, 32'h0009_0003, 32'h0001_0001};
    logic        ffill[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    obs_t o;
    exp_t e;
    sb_q.push_back('{lookups: 0, maddr: 32'h0001_0040, data: 32'h0001_0040 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 3});
    sb_q.push_back('{lookups: 1, maddr: 32'h0001_0040, data: 32'h0001_0040 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    sb_q.push_back('{lookups: 1, maddr: 32'h0009_0008, data: 32'h0009_0008 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    sb_q.push_back('{lookups: 1, maddr: 32'h0009_0008, data: 32'h0009_0008 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    sb_q.push_back('{lookups: 1, maddr: 32'h0001_0044, data: 32'h0001_0044 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    for (int k = 0; k < 5; k++) begin
      drive(addr[k], 1'b0, 32'h0, ent[k], 1'b0, ffill[k], o);
      if (k == 0) begin
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
      end
      e = sb_q.pop_front();
      n_cmp++;
      if (o.lookups !== e.lookups || o.maddr !== e.maddr || o.data !== e.data) begin
        n_fail++;
        $display("[TB] FAIL flush_%0d got lookups=%0d addr=%h data=%h required lookups=%0d addr=%h data=%h",
                 k, o.lookups, o.maddr, o.data, e.lookups, e.maddr, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr[3] = '{32'h0000_5ABC, 32'h0000_5FFC, 32'h0000_0004};
    logic        wr[3]   = '{1'b0, 1'b1, 1'b0};
    obs_t ob[3];
    exp_t e;
    sb_q.push_back('{lookups: 0, maddr: 32'h0009_0ABC, data: 32'h0009_0ABC ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 3});
    sb_q.push_back('{lookups: 0, maddr: 32'h0009_0FFC, data: 32'hDEAD_BEEF, fault: 1'b0, faddr: 32'h0, cycles: 3});
    sb_q.push_back('{lookups: 0, maddr: 32'h0001_0004, data: 32'h0001_0004 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 3});
    for (int k = 0; k < 3; k++) begin
      drive(addr[k], wr[k], 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, ob[k]);
    end
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (ob[k].lookups !== e.lookups || ob[k].maddr !== e.maddr || ob[k].mwe !== wr[k] ||
          ob[k].mrd !== !wr[k] || ob[k].cycles !== e.cycles ||
          (wr[k] ? ob[k].mdata : ob[k].data) !== e.data) begin
        n_fail++;
        $display("[TB] FAIL b2b_%0d got lookups=%0d addr=%h rd=%b we=%b cyc=%0d data=%h wdata=%h required lookups=%0d addr=%h we=%b cyc=%0d data=%h",
                 k, ob[k].lookups, ob[k].maddr, ob[k].mrd, ob[k].mwe, ob[k].cycles, ob[k].data, ob[k].mdata,
                 e.lookups, e.maddr, wr[k], e.cycles, e.data);
      end
    end
  endtask

  task automatic test_write_protect();
    obs_t o;
    exp_t e;
`ifdef MMU_XLATE_WP_EN
    sb_q.push_back('{lookups: 1, maddr: 32'h0, data: 32'h0, fault: 1'b1, faddr: 32'h0000_6000, cycles: 2});
    drive(32'h0000_6000, 1'b1, 32'h0BAD_F00D, 32'h0002_0001, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.fault !== 1'b1 || o.faddr !== e.faddr || o.mem_seen !== 0) begin
      n_fail++; $display("[TB] FAIL wp_fault got fault=%b addr=%h mem_cycles=%0d required fault=1 addr=%h mem_cycles=0",
                         o.fault, o.faddr, o.mem_seen, e.faddr);
    end
`else
    sb_q.push_back('{lookups: 1, maddr: 32'h0002_0000, data: 32'h0BAD_F00D, fault: 1'b0, faddr: 32'h0, cycles: 4});
    drive(32'h0000_6000, 1'b1, 32'h0BAD_F00D, 32'h0002_0001, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.fault !== 1'b0 || o.maddr !== e.maddr || o.mwe !== 1'b1 || o.mdata !== e.data) begin
      n_fail++; $display("[TB] FAIL wp_off got fault=%b addr=%h we=%b data=%h required fault=0 addr=%h we=1 data=%h",
                         o.fault, o.maddr, o.mwe, o.mdata, e.maddr, e.data);
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    exp_t e;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    bus.cpu_addr_i = 32'h0000_0100;
    bus.cpu_rd_i   = 1'b1;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bus.mem_rd_o) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_setup mem_rd_o got %b required 1", seen); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_rd_o, bus.cpu_ack_o, bus.tlb_lookup_o} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL rst_async got %b required 000", {bus.mem_rd_o, bus.cpu_ack_o, bus.tlb_lookup_o});
    end
    bus.cpu_rd_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb_q.push_back('{lookups: 1, maddr: 32'h0001_0100, data: 32'h0001_0100 ^ MEM_KEY, fault: 1'b0, faddr: 32'h0, cycles: 4});
    drive(32'h0000_0100, 1'b0, 32'h0, 32'h0001_0001, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.lookups !== e.lookups || o.maddr !== e.maddr || o.data !== e.data) begin
      n_fail++; $display("[TB] FAIL rst_rewalk got lookups=%0d addr=%h data=%h required lookups=%0d addr=%h data=%h",
                         o.lookups, o.maddr, o.data, e.lookups, e.maddr, e.data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_cold_read();
    test_hit();
    test_replacement();
    test_fault();
    test_flush();
    test_back_to_back();
    test_write_protect();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
